// File: rtl/uart_tx_fifo.sv
// Show-ahead byte FIFO feeding uart_transmitter: host pushes one byte per clock,
// the head byte is presented on tx_data/tx_valid and popped when tx_ready is high.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [DATA_BITS-1:0]      wr_data,
  input  logic                      flush,
  input  logic                      ovf_clr,
  input  logic                      tx_ready,
  output logic                      tx_valid,
  output logic [DATA_BITS-1:0]      tx_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LVL_W  = ADDR_W + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic                 do_push, do_pop, rejected;

  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign overflow = ovf_q;

  // Full is judged on the pre-edge level, so a pop never frees a slot for a same-cycle push.
  assign do_push  = wr_en && !full;
  assign rejected = wr_en && full;
  assign do_pop   = tx_valid && tx_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (do_push && !do_pop)      level_d = level_q + LVL_W'(1);
    else if (do_pop && !do_push) level_d = level_q - LVL_W'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    if (rejected)     ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; stale entries are never visible because tx_data is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo, checked every cycle against a
// queue-based model of the FIFO contents and the sticky overflow flag.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       flush = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       tx_ready = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;

  uart_tx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .ovf_clr(ovf_clr), .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    chk("level", int'(level), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == DEPTH));
    chk("tx_valid", int'(tx_valid), int'(n != 0));
    chk("tx_data", int'(tx_data), (n != 0) ? int'(mq[0]) : 0);
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  // Apply one set of inputs for one clock edge, advance the model, re-check at the falling edge.
  task automatic cycle(input logic w, input logic [7:0] d, input logic fl,
                       input logic oc, input logic rdy);
    logic was_full, pop;
    wr_en = w; wr_data = d; flush = fl; ovf_clr = oc; tx_ready = rdy;
    was_full = (mq.size() == DEPTH);
    pop      = (mq.size() != 0) && rdy;
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (w && !was_full) mq.push_back(d);
    end
    if (w && was_full) m_ovf = 1'b1;
    else if (oc)       m_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0; tx_ready = 1'b0;
    check_model();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    chk("rst_empty", int'(empty), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_tx_valid", int'(tx_valid), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_full", int'(full), 0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int wp, rp;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model();

    // Reset with bytes queued
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst_level", int'(level), 3);
    async_reset();
    @(negedge clk);
    check_model();

    // Burst of three, drained one per accept
    cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hB4, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    chk("burst_level", int'(level), 3);
    chk("burst_head0", int'(tx_data), 'hAA);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("burst_level2", int'(level), 2);
    chk("burst_head1", int'(tx_data), 'hB4);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("burst_level1", int'(level), 1);
    chk("burst_head2", int'(tx_data), 'h12);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("burst_level0", int'(level), 0);

    // Fill to DEPTH, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_level", int'(level), 16);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_level", int'(level), 16);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_byte", int'(tx_data), i);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    chk("drain_empty", int'(empty), 1);

    // Full with simultaneous push and pop: push rejected
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
    chk("fullpp_level", int'(level), 15);
    chk("fullpp_full", int'(full), 0);
    chk("fullpp_ovf", int'(overflow), 1);
    for (int i = 1; i < DEPTH; i++) begin
      chk("fullpp_byte", int'(tx_data), 'h20 + i);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    chk("fullpp_empty", int'(empty), 1);

    // Flush with push keeps overflow; ovf_clr clears it
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fl_pre_level", int'(level), 3);
    cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    chk("fl_level", int'(level), 0);
    chk("fl_empty", int'(empty), 1);
    chk("fl_ovf", int'(overflow), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("clr_ovf", int'(overflow), 0);

    // Empty with push and ready together: no pop, valid next cycle
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
    chk("e_valid", int'(tx_valid), 1);
    chk("e_data", int'(tx_data), 'h5A);
    chk("e_level", int'(level), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Set-wins: ovf_clr coincident with a rejected push
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("setwins_ovf", int'(overflow), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

    // Randomised phases with varying push/pop pressure
    for (int ph = 0; ph < 8; ph++) begin
      wp = (ph % 2 == 0) ? 80 : 30;
      rp = (ph % 2 == 0) ? 30 : 80;
      for (int c = 0; c < 300; c++) begin
        cycle(($urandom_range(99) < wp), 8'($urandom), ($urandom_range(99) < 2),
              ($urandom_range(99) < 5), ($urandom_range(99) < rp));
      end
      if (ph == 4) begin
        async_reset();
        @(negedge clk);
        check_model();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
